// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
package fifo_pkg;

  // Default data word width; must match the FIFO this block reads from.
  localparam int FIFO_WIDTH_DEFAULT = 16;

  // Output buffer depth. Two entries are enough to cover the FIFO's
  // one-cycle read latency at full throughput.
  localparam int BUF_DEPTH = 2;

  // Occupancy counter width, able to represent 0..BUF_DEPTH.
  localparam int OCC_WIDTH = $clog2(BUF_DEPTH + 1);

  typedef logic [FIFO_WIDTH_DEFAULT-1:0] word_t;

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry in-order output buffer: tail push, head pop, synchronous flush.
// Entry 0 is always the head, so the head word is a plain register output.
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int W = FIFO_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [W-1:0]         push_data_i,
  input  logic                 pop_i,
  output logic [W-1:0]         head_o,
  output logic [OCC_WIDTH-1:0] occ_o
);

  logic [W-1:0]         entry_q [BUF_DEPTH];
  logic [W-1:0]         entry_d [BUF_DEPTH];
  logic [OCC_WIDTH-1:0] occ_q;
  logic [OCC_WIDTH-1:0] occ_d;

  // Next-state: flush empties the buffer; otherwise shift on pop, write at tail on push.
  // The caller guarantees no push into a full buffer and no pop from an empty one.
  always_comb begin
    entry_d = entry_q;
    occ_d   = occ_q;
    if (flush_i) begin
      occ_d = '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          entry_d[occ_q[0]] = push_data_i;
          occ_d             = occ_q + OCC_WIDTH'(1);
        end
        2'b01: begin
          entry_d[0] = entry_q[1];
          occ_d      = occ_q - OCC_WIDTH'(1);
        end
        2'b11: begin
          if (occ_q == OCC_WIDTH'(1)) begin
            entry_d[0] = push_data_i;
          end else begin
            entry_d[0] = entry_q[1];
            entry_d[1] = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '{default: '0};
      occ_q   <= '0;
    end else begin
      entry_q <= entry_d;
      occ_q   <= occ_d;
    end
  end

  assign head_o = entry_q[0];
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: issues reads, absorbs the
// one-cycle read latency in a 2-entry buffer and presents a valid/ready stream.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic                  idle
);

  logic [OCC_WIDTH-1:0] occ;
  logic [OCC_WIDTH:0]   level;
  logic [OCC_WIDTH:0]   limit;
  logic                 inflight_q;
  logic                 inflight_d;
  logic [CNT_WIDTH-1:0] beat_q;
  logic [CNT_WIDTH-1:0] beat_d;
  logic                 pop;
  logic                 push;

  assign m_valid = (occ != '0);
  assign pop     = m_valid & m_ready;
  // A word returning from a read issued before a flush edge is dropped.
  assign push    = inflight_q & ~flush;

  fifo_out_buf #(
    .W (FIFO_WIDTH)
  ) u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (fifo_data),
    .pop_i       (pop),
    .head_o      (m_data),
    .occ_o       (occ)
  );

  // Read issue: only when the buffer plus in-flight word, net of this cycle's pop,
  // leaves room; never on an empty FIFO, during flush or while in reset.
  always_comb begin
    level      = {1'b0, occ} + (OCC_WIDTH + 1)'(inflight_q);
    limit      = (OCC_WIDTH + 1)'(BUF_DEPTH) + (OCC_WIDTH + 1)'(pop);
    fifo_rd_en = ~rst & ~flush & ~fifo_empty & (level < limit);
    inflight_d = fifo_rd_en;
    beat_d     = beat_q + CNT_WIDTH'(pop);
  end

  // In-flight flag and wrapping delivered-beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
    end
  end

  assign beat_count = beat_q;
  assign idle       = rst | ((occ == '0) & ~inflight_q & fifo_empty);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural 1-cycle-latency FIFO.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty;
  logic [15:0] fifo_data = '0;
  logic        fifo_rd_en;
  logic        flush = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic [3:0]  beat_count;
  logic        idle;

  int errors = 0;
  int checks = 0;

  // FIFO model state
  logic [15:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        fifo_clr = 1'b0;
  int          rd_total = 0;
  logic        underflow = 1'b0;

  // Stream monitor state
  logic [15:0] rx [0:127];
  int          pop_cyc [0:127];
  int          rx_cnt = 0;
  int          cyc = 0;

  int          r0;

  fifo_stream_reader #(
    .FIFO_WIDTH (16),
    .CNT_WIDTH  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .beat_count (beat_count),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  // FIFO model with registered read data, plus stream handshake monitor
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (fifo_rd_en) begin
      rd_total = rd_total + 1;
      if (rd_ptr == wr_ptr) begin
        underflow = 1'b1;
      end else begin
        fifo_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
    end
    if (fifo_clr) rd_ptr <= wr_ptr;
    if (m_valid && m_ready) begin
      rx[rx_cnt]      = m_data;
      pop_cyc[rx_cnt] = cyc;
      $display("beat %0d: data=%04h cycle=%0d", rx_cnt, m_data, cyc);
      rx_cnt = rx_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int n, input logic [15:0] first);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = first + 16'(i);
      wr_ptr      = wr_ptr + 1;
    end
  endtask

  // Wait on negedges until the monitor has seen 'target' beats, bounded by 'budget' cycles
  task automatic wait_rx(input int target, input int budget);
    int n;
    n = 0;
    while (rx_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_rx", 32'(rx_cnt), 32'(target));
  endtask

  initial begin
    // Reset values while rst is held
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_rd_en",   32'(fifo_rd_en), 32'd0);
    chk("rst_beat",    32'(beat_count), 32'd0);
    chk("rst_idle",    32'(idle), 32'd1);
    chk("rst_m_data",  32'(m_data), 32'd0);

    // Empty FIFO for 10 cycles: no reads, idle
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("empty_reads",   32'(rd_total), 32'd0);
    chk("empty_m_valid", 32'(m_valid), 32'd0);
    chk("empty_idle",    32'(idle), 32'd1);
    chk("empty_beat",    32'(beat_count), 32'd0);

    // Streaming with m_ready=1: words 1..8
    m_ready = 1'b1;
    preload(8, 16'h0001);
    #1;
    chk("t2_first_rd", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    chk("t2_lat_n1", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("t2_lat_n2_valid", 32'(m_valid), 32'd1);
    chk("t2_lat_n2_data",  32'(m_data), 32'h0001);
    wait_rx(8, 30);
    for (int i = 0; i < 8; i++) chk("t2_order", 32'(rx[i]), 32'(i + 1));
    chk("t2_no_gaps", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);
    chk("t2_beat", 32'(beat_count), 32'd8);
    chk("t2_idle", 32'(idle), 32'd1);
    chk("t2_underflow", 32'(underflow), 32'd0);

    // Backpressure: exactly two reads, head held stable
    m_ready = 1'b0;
    r0 = rd_total;
    preload(8, 16'h0001);
    repeat (6) @(negedge clk);
    chk("t3_reads", 32'(rd_total - r0), 32'd2);
    chk("t3_rd_en", 32'(fifo_rd_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_valid_hold", 32'(m_valid), 32'd1);
      chk("t3_data_hold",  32'(m_data), 32'h0001);
      @(negedge clk);
    end
    m_ready = 1'b1;
    wait_rx(16, 40);
    for (int i = 0; i < 8; i++) chk("t3_order", 32'(rx[8 + i]), 32'(i + 1));
    chk("t3_no_gaps", 32'(pop_cyc[15] - pop_cyc[8]), 32'd7);
    chk("t3_beat_wrap16", 32'(beat_count), 32'd0);

    // Flush with one word buffered and one in flight
    m_ready = 1'b0;
    preload(4, 16'h0011);
    #1;
    chk("t4_rd1", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t4_pre_valid", 32'(m_valid), 32'd1);
    chk("t4_pre_data",  32'(m_data), 32'h0011);
    flush = 1'b1;
    #1;
    chk("t4_flush_rd_en", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("t4_post_valid", 32'(m_valid), 32'd0);
    chk("t4_post_beat",  32'(beat_count), 32'd0);
    #1;
    chk("t4_next_rd", 32'(fifo_rd_en), 32'd1);
    m_ready = 1'b1;
    wait_rx(18, 20);
    chk("t4_next_word", 32'(rx[16]), 32'h0013);
    chk("t4_last_word", 32'(rx[17]), 32'h0014);
    chk("t4_beat", 32'(beat_count), 32'd2);

    // Asynchronous reset with a full buffer
    m_ready = 1'b0;
    preload(4, 16'h0021);
    repeat (5) @(negedge clk);
    chk("t5_valid", 32'(m_valid), 32'd1);
    chk("t5_data",  32'(m_data), 32'h0021);
    m_ready = 1'b1;
    #1;
    chk("t5_rd_en", 32'(fifo_rd_en), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_async_valid", 32'(m_valid), 32'd0);
    chk("t5_async_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t5_async_beat",  32'(beat_count), 32'd0);
    chk("t5_async_data",  32'(m_data), 32'd0);
    chk("t5_async_idle",  32'(idle), 32'd1);
    @(negedge clk);
    fifo_clr = 1'b1;
    @(negedge clk);
    fifo_clr = 1'b0;
    rst      = 1'b0;
    m_ready  = 1'b0;
    #1;
    chk("t5_post_idle",  32'(idle), 32'd1);
    chk("t5_post_valid", 32'(m_valid), 32'd0);

    // Counter wrap: 17 beats on a 4-bit counter
    m_ready = 1'b1;
    preload(17, 16'h0040);
    wait_rx(18 + 15, 40);
    chk("t6_beat15", 32'(beat_count), 32'd15);
    wait_rx(18 + 16, 5);
    chk("t6_beat_wrap", 32'(beat_count), 32'd0);
    wait_rx(18 + 17, 5);
    chk("t6_beat_end", 32'(beat_count), 32'd1);
    chk("t6_last_word", 32'(rx[34]), 32'h0050);
    chk("underflow_total", 32'(underflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
